// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared types for the execute-stage M-extension unit
package core_pkg;

    localparam int REGID_W = 5;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_div.sv
// rtl/muldiv_div.sv - iterative radix-2 restoring divider on unsigned magnitudes
module muldiv_div #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CW = $clog2(XLEN);

    logic [CW-1:0]   cnt;
    logic            running;
    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dvs_q;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            take;

    // quotient/remainder are the outcome of the current step, so on the
    // last iteration the caller can capture the final values in the same cycle
    always_comb begin
        shifted   = {rem_q, quo_q[XLEN-1]};
        diff      = shifted - {1'b0, dvs_q};
        take      = ~diff[XLEN];
        quotient  = {quo_q[XLEN-2:0], take};
        remainder = take ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    end

    assign done = running && (cnt == CW'(XLEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            running <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
        end else if (abort) begin
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            cnt     <= '0;
            running <= 1'b1;
            quo_q   <= dividend;
            rem_q   <= '0;
            dvs_q   <= divisor;
        end else if (running) begin
            quo_q <= quotient;
            rem_q <= remainder;
            cnt   <= cnt + 1'b1;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - M-extension multiply/divide unit for EX; CORE_DIV_SHORTCUT_EN enables early div-by-zero/overflow
module ex_muldiv
    import core_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               start,
    input  logic [2:0]         opcode,
    input  logic [XLEN-1:0]    op1,
    input  logic [XLEN-1:0]    op2,
    input  logic [REGID_W-1:0] regid,
    output logic               busy,
    output logic               done,
    output logic [XLEN-1:0]    result,
    output logic [REGID_W-1:0] result_regid
);

    localparam int MCW = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;

    muldiv_state_e      state, state_nxt;
    muldiv_op_e         op_q;
    logic [XLEN-1:0]    a_q, b_q;
    logic [REGID_W-1:0] regid_q;
    logic [MCW-1:0]     mcnt;

    logic            accept, shortcut, div_start, div_done;
    logic [XLEN-1:0] sc_result, div_mag1, div_mag2, div_q, div_r;
    logic [XLEN-1:0] mul_res, div_res, q_fix, r_fix;
    logic [2*XLEN-1:0] mul_a, mul_b, prod;
    logic            in_signed, in_neg1, in_neg2, ext1, ext2, neg1, neg2;

    assign accept = start && !flush && (state == S_IDLE || state == S_DONE);
    assign busy   = (state == S_MUL) || (state == S_DIV);
    assign done   = (state == S_DONE);

    assign in_signed = !opcode[0];
    assign in_neg1   = in_signed && op1[XLEN-1];
    assign in_neg2   = in_signed && op2[XLEN-1];
    assign div_mag1  = in_neg1 ? -op1 : op1;
    assign div_mag2  = in_neg2 ? -op2 : op2;

`ifdef CORE_DIV_SHORTCUT_EN
    logic sc_div0, sc_ovf;
    assign sc_div0   = (op2 == '0);
    assign sc_ovf    = in_signed && (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
    assign shortcut  = opcode[2] && (sc_div0 || sc_ovf);
    assign sc_result = opcode[1] ? (sc_div0 ? op1 : '0) : (sc_div0 ? '1 : op1);
`else
    assign shortcut  = 1'b0;
    assign sc_result = '0;
`endif

    assign div_start = accept && opcode[2] && !shortcut;

    muldiv_div #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .abort     (flush),
        .dividend  (div_mag1),
        .divisor   (div_mag2),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    // operands are two's-complement extended to 2*XLEN so a plain product is exact
    always_comb begin
        ext1    = ((op_q == OP_MULH) || (op_q == OP_MULHSU)) && a_q[XLEN-1];
        ext2    = (op_q == OP_MULH) && b_q[XLEN-1];
        mul_a   = {{XLEN{ext1}}, a_q};
        mul_b   = {{XLEN{ext2}}, b_q};
        prod    = mul_a * mul_b;
        mul_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    // a zero divisor keeps the all-ones quotient regardless of operand signs
    always_comb begin
        neg1    = !op_q[0] && a_q[XLEN-1];
        neg2    = !op_q[0] && b_q[XLEN-1];
        q_fix   = ((neg1 ^ neg2) && (b_q != '0)) ? -div_q : div_q;
        r_fix   = neg1 ? -div_r : div_r;
        div_res = op_q[1] ? r_fix : q_fix;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                state_nxt = S_IDLE;
                if (accept) begin
                    if (!opcode[2]) begin
                        state_nxt = S_MUL;
                    end else begin
                        state_nxt = shortcut ? S_DONE : S_DIV;
                    end
                end
            end
            S_MUL:   if (mcnt == '0) state_nxt = S_DONE;
            S_DIV:   if (div_done) state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush) begin
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q         <= OP_MUL;
            a_q          <= '0;
            b_q          <= '0;
            regid_q      <= '0;
            mcnt         <= '0;
            result       <= '0;
            result_regid <= '0;
        end else begin
            if (accept) begin
                op_q    <= muldiv_op_e'(opcode);
                a_q     <= op1;
                b_q     <= op2;
                regid_q <= regid;
                mcnt    <= MCW'(MUL_STAGES - 1);
            end else if (state == S_MUL && mcnt != '0) begin
                mcnt <= mcnt - 1'b1;
            end
            if (!flush) begin
                if (accept && shortcut) begin
                    result       <= sc_result;
                    result_regid <= regid;
                end else if (state == S_MUL && mcnt == '0) begin
                    result       <= mul_res;
                    result_regid <= regid_q;
                end else if (state == S_DIV && div_done) begin
                    result       <= div_res;
                    result_regid <= regid_q;
                end
            end
        end
    end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Multi-cycle RV32M/RV64M multiply/divide unit in the execute stage, next to the single-cycle ALU and branch unit. EX starts an operation with forwarded operands and stalls the pipeline while `busy` is high. The multiplier is pipelined with parametrised depth; the divider is an iterative radix-2 restoring divider. The unit supports flush, so a squashed instruction never writes back.

## Interface
- `XLEN`, default 32: operand and result width; 32 or 64.
- `MUL_STAGES`, default 2: multiplier latency in cycles; must be at least 1.
- `clk` in 1: core clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: abort any in-flight operation (ex_flush).
- `start` in 1: request a new operation.
- `opcode` in 3: M-extension funct3. MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
- `op1` in XLEN: rs1 value after forwarding.
- `op2` in XLEN: rs2 value after forwarding.
- `regid` in 5: destination register id.
- `busy` out 1: operation in flight; EX stalls on it.
- `done` out 1: one-cycle pulse; `result` is valid in this cycle.
- `result` out XLEN: result; held until the next `done`.
- `result_regid` out 5: destination register of `result`.

## Operation
- States: IDLE, MUL, DIV, DONE.
- A start is accepted when `start`=1, `flush`=0 and the state is IDLE or DONE.
  - On acceptance, latch operands, opcode and regid.
  - opcode[2]=0 moves to MUL; opcode[2]=1 moves to DIV.
- `start` in MUL or DIV is ignored. EX must hold the request stable while `busy` is high.
- MUL path:
  - Form a 2·XLEN product. Sign-extend op1 for MULH/MULHSU. Sign-extend op2 for MULH only.
  - MUL returns the low XLEN bits; all other mul opcodes return the high XLEN bits.
  - A counter runs from MUL_STAGES-1 down to 0, then the state moves to DONE.
- DIV path:
  - Signed ops use absolute values of the operands.
  - Run XLEN shift/subtract iterations, counting 0..XLEN-1.
  - Then negate: quotient if the operand signs differ; remainder if the dividend was negative.
  - Then move to DONE.
- Division by zero: quotient is all ones; remainder equals the dividend.
- Overflow (DIV/REM of most-negative by -1): quotient equals the dividend; remainder is 0.
- In DONE: `done`=1 and `busy`=0 for exactly one cycle. Next state is IDLE, or a new operation if one is accepted.
- Flush in any state: next state is IDLE, with no `done` and no `result` update. Flush beats a concurrent `start`.
- An asynchronous reset mid-operation clears everything; no result is produced.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `result`=0, `result_regid`=0.
  - State is IDLE; all counters are 0.
- Start accepted in cycle T0: `busy`=1 from T1.
- MUL: `done` in cycle T(MUL_STAGES+1).
- DIV: iterations run in T1..T(XLEN). Sign fix-up happens on entry to DONE. `done` is in T(XLEN+1).
- Back-to-back operations: a start in the DONE cycle is accepted, so there are no bubbles.
- `flush` is registered-synchronous: it takes effect at the next edge, and `busy`=0 in the following cycle.

## Configuration
- Macro: `CORE_DIV_SHORTCUT_EN`.
- Defined:
  - Divide-by-zero and signed overflow are detected in T0.
  - They go directly to DONE, so `done` is in T1.
- Undefined:
  - These cases run the full XLEN iterations.
  - The restoring algorithm plus sign fix-up produces the same architectural results, with `done` in T(XLEN+1).

## Structure
- Shared package `core_pkg`:
  - `muldiv_op_e` enum (the eight funct3 codes).
  - `muldiv_state_e` enum.
  - `REGID_W`=5.
- Sub-module `muldiv_div`: iterative restoring divider with its own counter and start/done handshake.
  - Takes unsigned magnitudes and produces unsigned quotient and remainder.
  - `ex_muldiv` does the sign handling and the shortcut logic.

## Test plan
- MUL, op1=7, op2=0xFFFFFFFD (−3), MUL_STAGES=2, start at T0 -> `done` at T3, `result`=0xFFFFFFEB.
- MULH 0x80000000×0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
- DIV −7/2 -> 0xFFFFFFFD at T33. REM −7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5.
  - With the macro: `done` at T1.
  - Without the macro: `done` at T33.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same -> 0.
- DIV started at T0 with `flush` at T10 -> `busy`=0 at T11 and no `done` pulse. MUL started at T11 -> `done` at T14. `rst_n` pulsed low mid-DIV -> all outputs 0 immediately.
